// File: rtl/nonce_result_pkg.sv
// Shared types and helpers for the nonce result queue.
// Entry layout is {job, nonce}; the counter helper saturates instead of wrapping.
package nonce_result_pkg;

    localparam int NONCE_W   = 32;
    localparam int JOB_W_DEF = 8;

    typedef struct packed {
        logic [JOB_W_DEF-1:0] job;
        logic [NONCE_W-1:0]   nonce;
    } entry_t;

    // Works on counters up to 32 bits wide; w is the real counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nonce_result_fifo_if.sv
// Result readout handshake: the queue drives valid and head data, the host drives ready.
// Head data is meaningful only while out_valid is high.
interface nonce_result_fifo_if #(
    parameter int JOB_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_nonce;
    logic [JOB_W-1:0] out_job;

    modport master (output out_valid, output out_nonce, output out_job, input  out_ready);
    modport slave  (input  out_valid, input  out_nonce, input  out_job, output out_ready);
endinterface

// File: rtl/nonce_fifo_mem.sv
// Storage array for the result queue: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none here; the caller only writes when a slot is free.
module nonce_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 40
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_dat
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/nonce_result_fifo.sv
// Captures miner hits tagged with the job id, drops back-to-back repeats, queues them FWFT.
// Latency: a hit into an empty queue is presented on out_if the next cycle.
// Backpressure: out_ready stalls the head; hits arriving while full are dropped and counted.
module nonce_result_fifo
    import nonce_result_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int JOB_W = JOB_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [JOB_W-1:0]       job_id,
    input  logic                   nonce_found,
    input  logic [NONCE_W-1:0]     nonce_in,
    nonce_result_fifo_if.master    out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       found_cnt,
    output logic [CNT_W-1:0]       overflow_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = JOB_W + NONCE_W;

    // Pointers carry one extra wrap bit so level == DEPTH and level == 0 stay distinct.
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 last_valid;
    logic [NONCE_W-1:0]   last_nonce;
    logic [JOB_W-1:0]     last_job;
    logic [ENTRY_W-1:0]   rd_dat;

    logic empty;
    logic full;
    logic dup;
    logic new_hit;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));

    assign dup     = last_valid && (nonce_in == last_nonce) && (job_id == last_job);
    assign new_hit = nonce_found && !flush && !dup;
    assign do_pop  = !empty && out_if.out_ready && !flush;
    // A pop in the same cycle frees the slot, so a full queue still takes the hit.
    assign do_push = new_hit && (!full || do_pop);
    assign do_drop = new_hit && full && !do_pop;

    nonce_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_dat  ({job_id, nonce_in}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_dat  (rd_dat)
    );

    // Gating on valid keeps stale array contents off the outputs after reset or flush.
    assign out_if.out_valid = !empty;
    assign out_if.out_nonce = empty ? '0 : rd_dat[NONCE_W-1:0];
    assign out_if.out_job   = empty ? '0 : rd_dat[ENTRY_W-1:NONCE_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            last_valid   <= 1'b0;
            last_nonce   <= '0;
            last_job     <= '0;
            found_cnt    <= '0;
            overflow_cnt <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_valid <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                found_cnt <= CNT_W'(sat_inc(32'(found_cnt), CNT_W));
            end
            if (do_drop) begin
                overflow_cnt <= CNT_W'(sat_inc(32'(overflow_cnt), CNT_W));
            end
            // Dedupe history tracks every distinct hit, whether or not it fit.
            if (new_hit) begin
                last_valid <= 1'b1;
                last_nonce <= nonce_in;
                last_job   <= job_id;
            end
        end
    end

endmodule

// File: tb/tb_nonce_result_fifo.sv
// Randomized and directed stimulus against a queue-based reference model;
// a second instance with 3-bit counters exercises saturation.
module tb_nonce_result_fifo;
    import nonce_result_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  job_id = '0;
    logic        nonce_found = 1'b0;
    logic [31:0] nonce_in = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  level, level_s;
    logic [15:0] found_cnt, overflow_cnt;
    logic [2:0]  found_cnt_s, overflow_cnt_s;

    nonce_result_fifo_if #(.JOB_W(8)) rif ();
    nonce_result_fifo_if #(.JOB_W(8)) rif_s ();
    assign rif.out_ready   = out_ready;
    assign rif_s.out_ready = out_ready;

    nonce_result_fifo #(.DEPTH(DEPTH), .CNT_W(16), .JOB_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush), .job_id(job_id),
        .nonce_found(nonce_found), .nonce_in(nonce_in), .out_if(rif),
        .level(level), .found_cnt(found_cnt), .overflow_cnt(overflow_cnt)
    );

    nonce_result_fifo #(.DEPTH(DEPTH), .CNT_W(3), .JOB_W(8)) dut_s (
        .clk(clk), .reset(reset), .flush(flush), .job_id(job_id),
        .nonce_found(nonce_found), .nonce_in(nonce_in), .out_if(rif_s),
        .level(level_s), .found_cnt(found_cnt_s), .overflow_cnt(overflow_cnt_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint sat(input longint v, input longint max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // Reference model: expected queue contents plus last distinct hit.
    entry_t      mq[$];
    logic        m_lv = 1'b0;
    logic [31:0] m_ln = '0;
    logic [7:0]  m_lj = '0;
    longint      m_found = 0;
    longint      m_ovf = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_lv = 1'b0;
            m_found = 0;
            m_ovf = 0;
        end else if (flush) begin
            mq.delete();
            m_lv = 1'b0;
        end else begin
            entry_t e;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (nonce_found && !(m_lv && nonce_in == m_ln && job_id == m_lj)) begin
                m_lv = 1'b1;
                m_ln = nonce_in;
                m_lj = job_id;
                if (mq.size() < DEPTH) begin
                    e.job = job_id;
                    e.nonce = nonce_in;
                    mq.push_back(e);
                    m_found++;
                end else begin
                    m_ovf++;
                end
            end
        end
    end

    // Monitor: compares the presented head and status against the model every cycle.
    always @(negedge clk) begin
        chk("level", 64'(level), 64'(mq.size()));
        chk("out_valid", 64'(rif.out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_nonce", 64'(rif.out_nonce), 64'(mq[0].nonce));
            chk("out_job", 64'(rif.out_job), 64'(mq[0].job));
        end
        chk("found_cnt", 64'(found_cnt), 64'(sat(m_found, 65535)));
        chk("overflow_cnt", 64'(overflow_cnt), 64'(sat(m_ovf, 65535)));
        chk("found_cnt_sat", 64'(found_cnt_s), 64'(sat(m_found, 7)));
        chk("overflow_cnt_sat", 64'(overflow_cnt_s), 64'(sat(m_ovf, 7)));
    end

    task automatic step(input logic nf, input logic [31:0] n, input logic [7:0] j,
                        input logic rdy, input logic fl);
        nonce_found = nf;
        nonce_in    = n;
        job_id      = j;
        out_ready   = rdy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, job_id, rdy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(rif.out_valid), 64'd0);
        chk({tag, "_nonce"}, 64'(rif.out_nonce), 64'd0);
        chk({tag, "_job"}, 64'(rif.out_job), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_found"}, 64'(found_cnt), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow_cnt), 64'd0);
    endtask

    initial begin
        logic [7:0] jr;
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic hit, then drain
        step(1'b1, 32'h0000_1234, 8'h05, 1'b0, 1'b0);
        chk("basic_valid", 64'(rif.out_valid), 64'd1);
        chk("basic_nonce", 64'(rif.out_nonce), 64'h1234);
        step(1'b0, 32'h0, 8'h05, 1'b1, 1'b0);
        chk("basic_drained", 64'(rif.out_valid), 64'd0);

        // Duplicate suppression and job change
        for (int i = 0; i < 3; i++) step(1'b1, 32'hABCD, 8'h05, 1'b0, 1'b0);
        chk("dup_level", 64'(level), 64'd1);
        step(1'b1, 32'hABCD, 8'h06, 1'b0, 1'b0);
        chk("dup_jobchg_found", 64'(found_cnt), 64'd3);
        idle(3, 1'b1);

        // Overflow: 10 pushes into 8 slots, then drain
        for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 8'h01, 1'b0, 1'b0);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_cnt", 64'(overflow_cnt), 64'd2);
        idle(10, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 8'h02, 1'b0, 1'b0);
        step(1'b1, 32'd9, 8'h02, 1'b1, 1'b0);
        chk("fullpp_level", 64'(level), 64'd8);
        chk("fullpp_ovf", 64'(overflow_cnt), 64'd2);
        chk("fullpp_head", 64'(rif.out_nonce), 64'd2);
        idle(9, 1'b1);

        // Flush with a coincident hit, then the same nonce again
        for (int i = 0; i < 3; i++) step(1'b1, 32'h31 + 32'(i), 8'h03, 1'b0, 1'b0);
        step(1'b1, 32'h77, 8'h03, 1'b1, 1'b1);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(rif.out_valid), 64'd0);
        step(1'b1, 32'h77, 8'h03, 1'b0, 1'b0);
        chk("flush_repush", 64'(rif.out_nonce), 64'h77);
        idle(2, 1'b1);

        // Async reset between edges while five entries are queued
        for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i), 8'h04, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h04, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b1);
        check_reset_outputs("post_rst");

        // Random traffic with frequent repeats, job changes, stalls and flushes
        jr = 8'h10;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) jr = 8'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 5)), jr,
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 49) == 0));
        end
        idle(12, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nonce_result_fifo.md
Name: nonce_result_fifo

Overview:
- Downstream of the Groestl miner core.
- Captures every cycle-level nonce_found/nonce_out hit, tags it with the current job id, suppresses back-to-back duplicates, and buffers results in a small first-word-fall-through queue.
- Host/readback logic drains results over a valid/ready interface.
- Keeps saturating hit and overflow counters for status registers.

Parameters:
- DEPTH, 8: queue entries; power of two, >= 2.
- CNT_W, 16: width of hit and overflow counters.
- JOB_W, 8: width of job tag.

Ports:
- clk  in  1  core clock, shared with miner.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous pulse when new work is loaded; discards queued results.
- job_id  in  JOB_W  tag of the work currently being mined.
- nonce_found  in  1  miner hit strobe; sampled each clk.
- nonce_in  in  32  nonce associated with nonce_found.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_nonce  out  32  head nonce.
- out_job  out  JOB_W  head job tag.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- found_cnt  out  CNT_W  accepted hits since reset; saturating.
- overflow_cnt  out  CNT_W  hits dropped because the queue was full; saturating.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_nonce=0, out_job=0, level=0, found_cnt=0, overflow_cnt=0, write/read pointers=0, last_valid=0.
- Push candidate: nonce_found=1 && !flush.
- Duplicate test: last_valid && nonce_in==last_nonce && job_id==last_job.
  - Duplicates are ignored: no write, no counter change.
- Non-duplicate candidate:
  - last_nonce/last_job/last_valid update regardless of space.
  - If space is available, the entry is written and found_cnt increments.
  - If no space is available, the entry is dropped and overflow_cnt increments.
- Space is available when level<DEPTH, or when level==DEPTH and a pop occurs the same cycle (simultaneous push+pop at full is accepted; level stays DEPTH).
- Pop: out_valid && out_ready. Head advances next cycle. Pop at empty is impossible (out_valid=0) and has no effect.
- Latency: push into empty queue -> out_valid=1 with that entry on the following cycle.
- FWFT: out_nonce/out_job are valid whenever out_valid=1, and stay stable while out_valid && !out_ready.
- Push+pop on the same cycle at a non-empty, non-full queue: level unchanged, ordering preserved.
- Flush has highest priority:
  - Next cycle: pointers=0, level=0, out_valid=0, last_valid=0.
  - A push or pop in the flush cycle is ignored and not counted.
  - found_cnt and overflow_cnt are retained.
- Counters hold at 2^CNT_W-1; no wrap.
- Pointer arithmetic is modulo DEPTH. level is computed from pointers with an extra wrap bit, so full and empty are unambiguous.
- Reset mid-operation: all contents are lost immediately. No partial entry is visible after release.

Decomposition:
- Package nonce_result_pkg:
  - NONCE_W=32.
  - Default JOB_W.
  - Packed entry typedef {job, nonce}.
  - Function for saturating increment.
- Sub-module nonce_fifo_mem: DEPTH x entry register array with write port and asynchronous read at the read pointer.
- Top module holds pointers, dedupe registers, counters and handshake logic.

Test Plan:
- Basic hit: reset, job_id=8'h05, nonce_found=1 for one cycle with nonce_in=32'h0000_1234 -> next cycle out_valid=1, out_nonce=32'h1234, out_job=8'h05, level=1, found_cnt=1; with out_ready=1 -> out_valid=0 after that cycle.
- Duplicate suppression:
  - nonce_found=1 for 3 consecutive cycles, nonce_in=32'hABCD each cycle -> exactly one entry, found_cnt=1.
  - Then job_id changes to 8'h06 with the same nonce -> second entry accepted, found_cnt=2.
- Overflow: out_ready=0, push 10 distinct nonces 1..10 with DEPTH=8 -> level=8, overflow_cnt=2. Drain yields nonces 1..8 in order.
- Full simultaneous push/pop: queue full with nonces 1..8, out_ready=1 and push nonce 9 in the same cycle -> level stays 8, overflow_cnt unchanged. Drain order is 2..9.
- Flush: 3 entries queued, flush=1 together with nonce_found=1 (nonce 32'h77) -> next cycle level=0, out_valid=0, found_cnt unchanged (3), 32'h77 never appears. A subsequent push of 32'h77 is accepted.
- Async reset mid-stream: assert reset between clk edges while level=5 -> outputs 0 immediately, before the next edge. After release, queue is empty and counters are 0.
